fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the five-stage RV64 pipeline, directly upstream of decode. It owns the program counter and issues one instruction-bus request at a time. It captures the returned 32-bit instruction and presents a `fetch_data_t` record (valid, raw_instr, pc) to decode through a one-entry output register with a valid/ready handshake. An optional redirect port lets a later stage reload the PC from `pcbranch`.

## Interface
- `RESET_PC`: default 64'h8000_0000. PC loaded at reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ireq_valid`  out  1  instruction bus request valid.
- `ireq_addr`  out  64  request address; equals the current PC.
- `iresp_data_ok`  in  1  response valid for the outstanding request.
- `iresp_data`  in  32  instruction word.
- `dataF`  out  97  `fetch_data_t` {valid, raw_instr, pc}; `dataF.valid` is the output-valid signal.
- `out_ready`  in  1  decode accepts `dataF` this cycle.
- `redirect_valid`  in  1  load a new PC (functional only with FETCH_REDIRECT_EN).
- `redirect_pc`  in  64  target PC.

## Operation
- State machine with three states:
  - IDLE: no request, output empty.
  - WAIT: request outstanding.
  - FULL: output register holds an instruction.
- `ireq_valid`=1 exactly when in WAIT.
  - `ireq_addr` is held stable from issue until `iresp_data_ok`.
  - At most one request is outstanding.
- IDLE → WAIT unconditionally on the next edge.
- WAIT, `iresp_data_ok`=1, drop flag clear:
  - load `dataF` = {1, `iresp_data`, pc};
  - pc ← pc+4 (64-bit, wraps modulo 2^64);
  - go to FULL.
- WAIT, `iresp_data_ok`=1, drop flag set: discard the data, clear drop, stay in WAIT. A new request at the current (redirected) PC is issued the next cycle.
- FULL, `out_ready`=1: clear `dataF.valid` and go to WAIT. The request at the already-incremented PC is issued the next cycle.
- FULL, `out_ready`=0: `dataF` is held bit-stable and no request is issued.
- `iresp_data_ok` in IDLE or FULL is ignored.
- Redirect (macro on), highest priority:
  - IDLE/FULL: pc ← `redirect_pc`, `dataF.valid` ← 0, go to WAIT. Overrides a simultaneous `out_ready`; the held instruction is not consumed.
  - WAIT without `iresp_data_ok`: pc ← `redirect_pc`, set drop. The bus request is never withdrawn: `ireq_valid` stays high and `ireq_addr` keeps the old PC until the response arrives.
  - WAIT with `iresp_data_ok` in the same cycle: discard the data, pc ← `redirect_pc`, clear drop, stay in WAIT.
  - A second redirect while drop is set overwrites the pc; the last redirect wins.
- `dataF.raw_instr` and `dataF.pc` are don't-care while `dataF.valid`=0 but must hold their last value (no X).

## Timing
- Reset values:
  - state = IDLE
  - pc = `RESET_PC`
  - drop = 0
  - `ireq_valid` = 0
  - `dataF` = 0
- Reset has priority over every input, including mid-request. The outstanding response is forgotten, and a `iresp_data_ok` arriving after reset deasserts is ignored unless WAIT has been re-entered.
- First edge with `reset`=0 enters WAIT. `ireq_valid`=1 with `ireq_addr`=`RESET_PC` in that following cycle.
- `iresp_data_ok` in cycle t → `dataF.valid`=1 in cycle t+1.
- `out_ready` in FULL cycle t → `ireq_valid`=1 at pc+4 in t+1.
- Steady-state throughput with a one-cycle-latency bus: one instruction every 3 cycles.
- `ireq_valid` and `dataF` are registered or pure state decodes. There is no combinational path from `out_ready` or `iresp_*` to any output.

## Configuration
- `FETCH_REDIRECT_EN` defined: redirect logic and the drop flag are built as described above.
- Not defined:
  - `redirect_valid` and `redirect_pc` are ignored (ports remain);
  - the drop flag is removed;
  - the PC advances strictly by +4.

## Test plan
- Reset then a 1-cycle-latency memory holding 0x00100093, 0x00208113, 0x0030c193 at 0x80000000/04/08, with `out_ready`=1 → `dataF` delivers (0x80000000, 0x00100093), (0x80000004, 0x00208113), (0x80000008, 0x0030c193), one every 3 cycles.
- `out_ready`=0 for 5 cycles while FULL at pc 0x80000004 → `dataF` stable, `ireq_valid`=0 throughout; the next request goes to 0x80000008 one cycle after `out_ready` rises.
- Macro on, `redirect_valid` with `redirect_pc`=0x80001000 while FULL and `out_ready`=1 → `dataF.valid`=0 next cycle, then `ireq_addr`=0x80001000.
- Macro on, redirect to 0x80001000 during WAIT, response 0xdeadbeef two cycles later → 0xdeadbeef never appears on `dataF`; the next request address is 0x80001000.
- `reset` pulsed for one cycle during WAIT at 0x80000008 → `ireq_valid`=0, then a request at 0x80000000; a late `iresp_data_ok` during reset produces no `dataF.valid`.
- Macro off, `redirect_valid` pulses every 4 cycles → the fetched PC sequence stays 0x80000000, 0x80000004, 0x80000008, …

Source files
------------

// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: owns the PC, keeps one bus request in flight, and hands {valid, raw_instr, pc} to decode.
// Build option: define FETCH_REDIRECT_EN to add the redirect port logic and the drop flag for a superseded in-flight response.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output logic [96:0] dataF,
   input  logic        out_ready,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);

   // Handshakes: a bus request is live while ireq_valid=1 and completes in the cycle iresp_data_ok=1;
   // decode takes dataF on any rising edge where dataF[96] (valid) and out_ready are both high.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] pc;
   logic [63:0] req_addr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

`ifdef FETCH_REDIRECT_EN
   logic        drop;
`else
   logic        unused_redirect;
   assign unused_redirect = ^{redirect_valid, redirect_pc};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_pc    <= 64'd0;
`ifdef FETCH_REDIRECT_EN
         drop      <= 1'b0;
`endif
      end
`ifdef FETCH_REDIRECT_EN
      else if (redirect_valid) begin
         pc        <= redirect_pc;
         out_valid <= 1'b0;
         state     <= WAIT;
         // A request already on the bus is never withdrawn; its response is discarded later.
         if (state == WAIT && !iresp_data_ok) begin
            drop <= 1'b1;
         end else begin
            drop     <= 1'b0;
            req_addr <= redirect_pc;
         end
      end
`endif
      else begin
         case (state)
            IDLE: begin
               state    <= WAIT;
               req_addr <= pc;
            end
            WAIT: begin
               if (iresp_data_ok) begin
`ifdef FETCH_REDIRECT_EN
                  if (drop) begin
                     drop     <= 1'b0;
                     req_addr <= pc;
                  end else
`endif
                  begin
                     out_valid <= 1'b1;
                     out_instr <= iresp_data;
                     out_pc    <= pc;
                     pc        <= pc + 64'd4;
                     state     <= FULL;
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  req_addr  <= pc;
                  state     <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ireq_valid = (state == WAIT);
   assign ireq_addr  = req_addr;
   assign dataF      = {out_valid, out_instr, out_pc};

endmodule
